// File: rtl/jesd204b_pkg.sv
// jesd204b_pkg: K-character codes, DLL state encoding and scrambler seed shared by the
// JESD204B lane data-link transmitter and its scrambler.
package jesd204b_pkg;

    localparam logic [7:0]  K28_0    = 8'h1C;   // /R/ multiframe start
    localparam logic [7:0]  K28_3    = 8'h7C;   // /A/ multiframe end
    localparam logic [7:0]  K28_4    = 8'h9C;   // /Q/ configuration start
    localparam logic [7:0]  K28_5    = 8'hBC;   // /K/ code-group sync
    localparam logic [31:0] CGS_WORD = {4{K28_5}};

    localparam logic [14:0] SCR_SEED = 15'h7F80;

    typedef enum logic [1:0] {
        ST_CGS  = 2'd0,
        ST_ILAS = 2'd1,
        ST_DATA = 2'd2
    } dll_state_e;

    typedef struct packed {
        logic [14:0] state;
        logic [31:0] word;
    } scr_result_t;

endpackage

// File: rtl/jesd204b_scrambler.sv
// jesd204b_scrambler: 32-bit self-synchronous scrambler 1+x^14+x^15, bit 7 of octet 0 first.
// The scrambled word is combinational; the history register steps once per consumed word.
module jesd204b_scrambler
    import jesd204b_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        advance,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    logic [14:0] history;
    scr_result_t res;

    // history[0] holds the most recent scrambled bit, history[14] the oldest
    function automatic scr_result_t scramble(input logic [14:0] hist, input logic [31:0] din);
        scr_result_t r;
        logic [14:0] h;
        logic        b;
        h      = hist;
        r.word = '0;
        for (int n = 31; n >= 0; n--) begin
            b         = din[n] ^ h[13] ^ h[14];
            r.word[n] = b;
            h         = {h[13:0], b};
        end
        r.state = h;
        return r;
    endfunction

    always_comb res = scramble(history, data_in);

    assign data_out = res.word;

    always_ff @(posedge clk) begin
        if (reset || init) begin
            history <= SCR_SEED;
        end else if (advance) begin
            history <= res.state;
        end
    end

endmodule

// File: rtl/jesd204b_dll_tx.sv
// jesd204b_dll_tx: JESD204B lane data-link layer transmitter (CGS -> ILAS -> DATA).
// Define JESD204B_SCRAMBLE_EN to scramble DATA octets; otherwise DATA passes through.
module jesd204b_dll_tx
    import jesd204b_pkg::*;
#(
    parameter int F       = 2,
    parameter int K       = 32,
    parameter int ILAS_MF = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         sync_n,
    input  logic [31:0]  tx_datain,
    input  logic [111:0] ilas_cfg,
    output logic [31:0]  tx_data,
    output logic [3:0]   tx_charisk,
    output logic         tx_ready,
    output logic         lmfc_edge
);

    localparam int WPM = F * K / 4;
    localparam int CW  = (WPM > 1) ? $clog2(WPM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WPM - 1);
    localparam logic [9:0]    OCT_LAST = 10'(F * K - 1);
    localparam logic [7:0]    MF_LAST  = 8'(ILAS_MF - 1);

    dll_state_e    state, state_nxt;
    logic [CW-1:0] lmfc_cnt;
    logic [7:0]    ilas_mf;
    logic          lmfc_last;

    logic [7:0]    cfg_oct [16];
    logic [31:0]   ilas_word;
    logic [3:0]    ilas_k;
    logic [31:0]   data_word;
    logic [31:0]   word_nxt;
    logic [3:0]    k_nxt;

    assign lmfc_last = (lmfc_cnt == CNT_LAST);

    // LMFC word counter runs regardless of link state
    always_ff @(posedge clk) begin
        if (reset) begin
            lmfc_cnt <= '0;
        end else if (lmfc_last) begin
            lmfc_cnt <= '0;
        end else begin
            lmfc_cnt <= lmfc_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != ST_ILAS) begin
            ilas_mf <= '0;
        end else if (lmfc_last) begin
            ilas_mf <= ilas_mf + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CGS;
        end else begin
            state <= state_nxt;
        end
    end

    // CGS leaves only on the last LMFC word so that ILAS begins on an LMFC edge
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CGS:  if (sync_n && lmfc_last) state_nxt = ST_ILAS;
            ST_ILAS: begin
                if (!sync_n) begin
                    state_nxt = ST_CGS;
                end else if (lmfc_last && ilas_mf == MF_LAST) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: if (!sync_n) state_nxt = ST_CGS;
            default: state_nxt = ST_CGS;
        endcase
        if (!en) state_nxt = ST_CGS;
    end

    always_comb begin
        for (int j = 0; j < 14; j++) begin
            cfg_oct[j] = ilas_cfg[8*(13-j) +: 8];
        end
        cfg_oct[14] = 8'h00;
        cfg_oct[15] = 8'h00;
    end

    // ILAS octet n of a multiframe: /R/ at 0, /A/ at the end, /Q/ + config in multiframe 1
    always_comb begin
        logic [9:0] oct_idx;
        logic [3:0] cfg_j;
        logic [7:0] oct;
        logic       kf;
        ilas_word = '0;
        ilas_k    = '0;
        oct_idx   = '0;
        cfg_j     = '0;
        oct       = '0;
        kf        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            oct_idx = 10'(lmfc_cnt) * 10'd4 + 10'(i);
            cfg_j   = 4'(oct_idx - 10'd2);
            oct     = oct_idx[7:0];
            kf      = 1'b0;
            if (oct_idx == 10'd0) begin
                oct = K28_0;
                kf  = 1'b1;
            end else if (oct_idx == OCT_LAST) begin
                oct = K28_3;
                kf  = 1'b1;
            end else if (ilas_mf == 8'd1 && oct_idx == 10'd1) begin
                oct = K28_4;
                kf  = 1'b1;
            end else if (ilas_mf == 8'd1 && oct_idx <= 10'd15) begin
                oct = cfg_oct[cfg_j];
            end
            ilas_word[8*(3-i) +: 8] = oct;
            ilas_k[3-i]             = kf;
        end
    end

`ifdef JESD204B_SCRAMBLE_EN
    jesd204b_scrambler u_scrambler (
        .clk      (clk),
        .reset    (reset),
        .init     (state == ST_CGS),
        .advance  (state == ST_DATA),
        .data_in  (tx_datain),
        .data_out (data_word)
    );
`else
    assign data_word = tx_datain;
`endif

    always_comb begin
        word_nxt = CGS_WORD;
        k_nxt    = 4'hF;
        case (state)
            ST_ILAS: begin
                word_nxt = ilas_word;
                k_nxt    = ilas_k;
            end
            ST_DATA: begin
                word_nxt = data_word;
                k_nxt    = 4'h0;
            end
            default: ;
        endcase
    end

    // Output register: one word per clk, lmfc_edge marks word 0 of each multiframe
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data    <= CGS_WORD;
            tx_charisk <= 4'hF;
            lmfc_edge  <= 1'b0;
        end else begin
            tx_data    <= word_nxt;
            tx_charisk <= k_nxt;
            lmfc_edge  <= (lmfc_cnt == '0);
        end
    end

    assign tx_ready = (state == ST_DATA);

endmodule
